aes_inv_cipher_ctrl: RTL and testbench
======================================

Name: aes_inv_cipher_ctrl

Overview:
Iterative AES decryption sequencer that sits directly upstream of the single-round inverse datapath (aes_inv_rounddata).
- Accepts one ciphertext block and a key-size mode per transaction.
- Holds the state register and drives the round counter, mode and data into the round datapath, one round per cycle.
- Requests round keys in reverse schedule order from an external key store.
- Returns the plaintext over a valid/ready handshake.

Parameters:
- KEY_IDX_W, 4, width of the round-key index presented to the key store.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  controller can accept a block
- in_data  in  128  ciphertext, byte 0 in bits [127:120]
- in_mode  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
- key_idx  out  KEY_IDX_W  key-schedule index of the round key needed this cycle
- round_key  in  128  key store's combinational response to key_idx, same cycle
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext
- out_err  out  1  block was submitted with illegal mode; qualified by out_valid
- busy  out  1  high in RUN

Behaviour:
- Reset values: in_ready=0 while rst_n low, then 1 from the first cycle in IDLE; out_valid=0, out_data=0, out_err=0, busy=0, key_idx=0. The FSM enters IDLE, the round counter is 0, and the state register is cleared.
- Nr per mode: 10, 12 or 14.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into the state register, latch in_mode, set round=0.
  - Legal mode: go to RUN.
  - Mode 11: go straight to DONE with out_err=1 and out_data=0.
- RUN:
  - in_ready=0; round counter, latched mode and state register feed the round datapath.
  - key_idx = Nr - round (Nr, Nr-1, ..., 0).
  - Each edge: state register <= datapath output; round <= round+1.
  - On the edge where round==Nr: capture the result into out_data and go to DONE.
  - Round 0 skips inverse mixcols; round Nr performs add-round-key only. Both are handled inside the datapath; the controller only sequences.
- DONE:
  - out_valid=1; out_data and out_err are held stable.
  - On out_valid&out_ready: go to IDLE and drop out_valid.
  - in_ready=0, except as defined under Optional Feature.
- Latency: out_valid rises Nr+1 clock edges after the accepting edge (11/13/15). Throughput is one block per Nr+3 cycles without the option.
- Inputs in_data and in_mode are ignored outside the accepting cycle. Changes during RUN have no effect.
- Backpressure: out_ready low holds DONE indefinitely with outputs stable. No data is lost.
- Round counter: 4 bits; it never exceeds 14, so there is no wrap.
- Reset asserted mid-RUN or mid-DONE: immediate abort to reset values; the in-flight block is discarded.
- round_key is sampled only in RUN. key_idx is held at 0 outside RUN.

Optional Feature:
- Macro AES_INV_CIPHER_B2B_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - On the same edge as an output handshake, if in_valid=1, the new block is latched and the FSM goes directly to RUN (or to DONE for mode 11).
  - Throughput becomes one block per Nr+2 cycles.
- Undefined:
  - in_ready=0 in DONE, and a mandatory IDLE cycle separates blocks.

Decomposition:
- Shared package aes_pkg:
  - mode enum (AES128/AES192/AES256/ILLEGAL);
  - constants NR_128=10, NR_192=12, NR_256=14;
  - function nr_of(mode);
  - FSM state enum.
- One sub-module instance: the existing aes_inv_rounddata, driven by round, mode, round_key and the state register.
- The controller contains only the FSM, counter, registers and handshake logic.

Test Plan:
- AES-128 (FIPS-197 C.1), key store loaded with the 000102..0f expansion.
  - Stimulus: in_data=69c4e0d86a7b0430d8cdb78070b4c55a, mode 00.
  - Required: out_data=00112233445566778899aabbccddeeff, out_valid 11 edges after accept, key_idx sequence 10..0.
- AES-192 (C.2).
  - Stimulus: in_data=dda97ca4864cdfe06eaf70a0ec0d7191, mode 01.
  - Required: same plaintext, latency 13.
- AES-256 (C.3).
  - Stimulus: in_data=8ea2b7ca516745bfeafc49904b496089, mode 10.
  - Required: same plaintext, latency 15.
- Backpressure and stability.
  - Stimulus: hold out_ready=0 for 20 cycles after completion; toggle in_data and in_valid during RUN.
  - Required: out_data stable, in_ready=0 throughout, plaintext unchanged.
- Illegal mode and reset.
  - Stimulus 1: mode 11.
    - Required: out_valid one edge after accept with out_err=1, out_data=0.
  - Stimulus 2: rst_n low at round 5 of an AES-128 block.
    - Required: immediate out_valid=0, busy=0; then the next block decrypts correctly.
- Back-to-back, with AES_INV_CIPHER_B2B_EN defined.
  - Stimulus: two C.1 blocks with in_valid and out_ready held high.
  - Required: the second accept occurs on the first output-handshake edge; outputs are 12 cycles apart.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: key-size modes, round counts and FSM states for the AES inverse cipher.
package aes_pkg;
  typedef enum logic [1:0] {AES128 = 2'b00, AES192 = 2'b01, AES256 = 2'b10, ILLEGAL = 2'b11} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  function automatic logic [3:0] nr_of(input mode_e m);
    return m == AES192 ? 4'(NR_192) : m == AES256 ? 4'(NR_256) : 4'(NR_128);
  endfunction
endpackage

// File: rtl/aes_inv_rounddata.sv
// aes_inv_rounddata: one inverse AES round step, shaped by the round index.
module aes_inv_rounddata
  import aes_pkg::*;
(
  input  logic [3:0]   round,
  input  mode_e        mode,
  input  logic [127:0] round_key,
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  logic [3:0]   nr;
  logic [127:0] t, m, u, v;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  // Inverse affine, then GF(2^8) inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] p, r;
    p = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [31:0] imc(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction
  assign nr = nr_of(mode);
  assign t  = state_in ^ round_key;
  assign u  = (round != 4'd0 && round != nr) ? m : t;
  assign state_out = round == nr ? t : v;
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign m[127-32*c -: 32] = imc(t[127-32*c -: 32]);
  end
  // Byte n sits at row n%4, column n/4; row r rotates right by r.
  for (genvar n = 0; n < 16; n++) begin : g_byte
    assign v[127-8*n -: 8] = inv_sbox(u[127-8*(4*(((n/4)-(n%4)+4)%4)+(n%4)) -: 8]);
  end
endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES decryption sequencer, one round per cycle.
// AES_INV_CIPHER_B2B_EN lets a new block be accepted on the output-handshake edge.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  input  logic [1:0]           in_mode,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         round_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 out_err,
  output logic                 busy
);
  state_e       state, state_nx;
  mode_e        mode;
  logic [3:0]   round, nr;
  logic [127:0] st, dp_out;
  logic         acc, last;
  assign nr        = nr_of(mode);
  assign busy      = state == RUN;
  assign out_valid = state == DONE;
  assign last      = busy && round == nr;
  assign key_idx   = busy ? KEY_IDX_W'(nr - round) : '0;
`ifdef AES_INV_CIPHER_B2B_EN
  assign in_ready  = rst_n && (state == IDLE || (out_valid && out_ready));
`else
  assign in_ready  = rst_n && state == IDLE;
`endif
  assign acc       = in_valid && in_ready;
  // An accept in DONE always coincides with the output handshake, so it takes priority.
  always_comb begin
    state_nx = state;
    if (acc) state_nx = &in_mode ? DONE : RUN;
    else if (last) state_nx = DONE;
    else if (out_valid && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode     <= AES128;
      round    <= '0;
      st       <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        st       <= in_data;
        mode     <= mode_e'(in_mode);
        round    <= '0;
        out_data <= '0;
        out_err  <= &in_mode;
      end else if (busy) begin
        st    <= dp_out;
        round <= last ? 4'd0 : round + 4'd1;
        if (last) out_data <= dp_out;
      end
    end
  end
  aes_inv_rounddata u_round (
    .round     (round),
    .mode      (mode),
    .round_key (round_key),
    .state_in  (st),
    .state_out (dp_out)
  );
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// tb_aes_inv_cipher_ctrl: directed FIPS-197 vectors, handshake, reset and back-to-back checks.
module tb_aes_inv_cipher_ctrl;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_INV_CIPHER_B2B_EN
  localparam int GAP = 0, PERIOD = 12;
`else
  localparam int GAP = 1, PERIOD = 13;
`endif
  logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic         in_ready, out_valid, out_err, busy;
  logic [127:0] in_data = '0, out_data, round_key;
  logic [1:0]   in_mode = '0;
  logic [3:0]   key_idx;
  logic [127:0] rk [16];
  int           checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign round_key = rk[key_idx];
  aes_inv_cipher_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r, c, b;
    p = x;
    r = 8'h01;
    c = 8'h63;
    for (int i = 1; i < 8; i++) begin
      p = mul(p, p);
      r = mul(r, p);
    end
    for (int i = 0; i < 8; i++) b[i] = r[i] ^ r[(i+4)%8] ^ r[(i+5)%8] ^ r[(i+6)%8] ^ r[(i+7)%8] ^ c[i];
    return b;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  // Key store: expansion of the key 00 01 02 ... (4*nk-1).
  task automatic load_keys(input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else rk[r] = '0;
    end
  endtask
  task automatic accept(input logic [1:0] m, input logic [127:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1;
    in_mode  = m;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  // Counts edges after the accepting edge until out_valid; kerr flags wrong key_idx,
  // in_ready high during RUN, or a wrong number of RUN cycles.
  task automatic wait_out(input int nr, input bit noise, output int lat, output int kerr);
    int j = 0;
    lat  = 0;
    kerr = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (busy) begin
        if (key_idx != 4'(nr - j) || in_ready) kerr++;
        j++;
      end
      if (noise) begin
        in_valid = 1'($urandom);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_mode  = 2'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 0;
    if (j != nr + 1) kerr++;
  endtask
  task automatic consume;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  task automatic block(input string tag, input int nk, input logic [1:0] m, input logic [127:0] ct,
                       input logic [127:0] pt, input bit err, input int exp_lat);
    int lat, kerr;
    if (nk > 0) load_keys(nk);
    accept(m, ct);
    wait_out(err ? -1 : nk + 6, 0, lat, kerr);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, out_data, pt);
    check({tag, "_err"}, out_err, err);
    check({tag, "_keyseq"}, kerr, 0);
    consume;
    @(negedge clk);
    check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, kerr, bad, e, na, nh;
    int a [2];
    int h [2];
    logic [127:0] hd [2];
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_outs", {out_valid, busy, out_err, key_idx}, 0);
    check("rst_data", out_data, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_ready", in_ready, 1);
    block("c1", 4, 2'b00, CT128, PT, 0, 11);
    block("c2", 6, 2'b01, CT192, PT, 0, 13);
    block("c3", 8, 2'b10, CT256, PT, 0, 15);
    // Illegal mode: DONE is entered on the accepting edge itself.
    block("ill", 0, 2'b11, CT128, '0, 1, 0);
    load_keys(4);
    accept(2'b00, CT128);
    wait_out(10, 1, lat, kerr);
    check("bp_lat", lat, 11);
    check("bp_keyseq", kerr, 0);
    bad = 0;
    repeat (20) begin
      if (!out_valid || in_ready || out_err || out_data !== PT) bad++;
      @(negedge clk);
    end
    check("bp_hold", bad, 0);
    check("bp_data", out_data, PT);
    consume;
    accept(2'b00, CT128);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_round5", {busy, key_idx}, {1'b1, 4'd5});
    #1 rst_n = 0;
    #1 check("mid_rst", {out_valid, busy, in_ready, key_idx}, 0);
    @(negedge clk);
    rst_n = 1;
    block("post_rst", 4, 2'b00, CT128, PT, 0, 11);
    load_keys(4);
    out_ready = 1;
    in_mode   = 2'b00;
    in_data   = CT128;
    in_valid  = 1;
    e = 0; na = 0; nh = 0;
    a[0] = -1; a[1] = -1; h[0] = -1; h[1] = -1; hd[0] = '0; hd[1] = '0;
    while (nh < 2 && e < 80) begin
      if (in_valid && in_ready && na < 2) begin
        a[na] = e;
        na++;
      end
      if (out_valid && out_ready) begin
        hd[nh] = out_data;
        h[nh]  = e;
        nh++;
      end
      @(posedge clk);
      e++;
      #1 if (na == 2) in_valid = 0;
      @(negedge clk);
    end
    out_ready = 0;
    in_valid  = 0;
    check("b2b_count", nh, 2);
    check("b2b_data0", hd[0], PT);
    check("b2b_data1", hd[1], PT);
    check("b2b_accept_gap", a[1] - h[0], GAP);
    check("b2b_period", h[1] - h[0], PERIOD);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
